multiprecision_add_sub: RTL and testbench

MULTIPRECISION_ADD_SUB -- requirements
Module: multiprecision_add_sub

---
 rtl/alu_pkg.sv | 20 ++
 rtl/add_sub_slice.sv | 15 +
 rtl/multiprecision_add_sub.sv | 122 ++++++++++++
 tb/tb_multiprecision_add_sub.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the multiprecision add/subtract unit.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD_U = 2'b00,
    ADD_S = 2'b01,
    SUB_U = 2'b10,
    SUB_S = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int unsigned MODE_SUB_BIT    = 1;
  localparam int unsigned MODE_SIGNED_BIT = 0;

endpackage

// File: rtl/add_sub_slice.sv
// Combinational WIDTH-bit adder slice with carry in/out; subtraction is
// handled by the caller feeding an inverted operand and carry.
module add_sub_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/multiprecision_add_sub.sv
// Multi-cycle add/subtract, one CHUNK_WIDTH slice per cycle, LSB first.
// Define ADD_SUB_FLAGS_EN to build the overflow/zero/negative flag logic.
module multiprecision_add_sub
  import alu_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [WORD_WIDTH-1:0] data_in_a,
  input  logic [WORD_WIDTH-1:0] data_in_b,
  input  logic                  carry_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WORD_WIDTH-1:0] sum,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  zero,
  output logic                  negative,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned SAFE_CW    = (CHUNK_WIDTH < 1) ? 1 : CHUNK_WIDTH;
  localparam int unsigned NUM_CHUNKS = WORD_WIDTH / SAFE_CW;
  localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  generate
    if ((CHUNK_WIDTH < 1) || (WORD_WIDTH < 2) || ((WORD_WIDTH % SAFE_CW) != 0)) begin : g_bad_params
      $error("multiprecision_add_sub: illegal WORD_WIDTH/CHUNK_WIDTH combination");
    end
  endgenerate

  state_t                 state, state_next;
  mode_t                  mode_r;
  logic [WORD_WIDTH-1:0]  a_r, b_r, sum_r;
  logic                   carry_r;
  logic [IDX_W-1:0]       idx;
  logic                   accept, done, sub;
  logic [CHUNK_WIDTH-1:0] a_chunk, b_chunk, s_chunk;
  logic                   c_chunk;

  assign in_ready  = (state == IDLE) && !rst;
  assign done      = (state == DONE);
  assign out_valid = done;
  assign accept    = in_valid && in_ready;
  assign sub       = mode_r[MODE_SUB_BIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (idx == LAST_IDX) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Subtraction runs as A + ~B + ~borrow, so the operand is inverted per slice
  // and the carry register is seeded with the inverted borrow at accept.
  assign a_chunk = a_r[idx*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign b_chunk = b_r[idx*CHUNK_WIDTH +: CHUNK_WIDTH] ^ {CHUNK_WIDTH{sub}};

  add_sub_slice #(.WIDTH(CHUNK_WIDTH)) u_slice (
    .a         (a_chunk),
    .b         (b_chunk),
    .carry_in  (carry_r),
    .sum       (s_chunk),
    .carry_out (c_chunk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r  <= ADD_U;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      mode_r  <= mode_t'(mode);
      a_r     <= data_in_a;
      b_r     <= data_in_b;
      sum_r   <= '0;
      carry_r <= carry_in ^ mode[MODE_SUB_BIT];
      idx     <= '0;
    end else if (state == BUSY) begin
      sum_r[idx*CHUNK_WIDTH +: CHUNK_WIDTH] <= s_chunk;
      carry_r <= c_chunk;
      idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  assign sum = sum_r;
  // Final adder carry means "no borrow" when subtracting.
  assign carry_out = done && (carry_r ^ sub);

`ifdef ADD_SUB_FLAGS_EN
  logic a_msb, b_eff_msb, s_msb;
  assign a_msb     = a_r[WORD_WIDTH-1];
  assign b_eff_msb = b_r[WORD_WIDTH-1] ^ sub;
  assign s_msb     = sum_r[WORD_WIDTH-1];
  assign overflow  = done && mode_r[MODE_SIGNED_BIT] && (a_msb == b_eff_msb) && (s_msb != a_msb);
  assign zero      = done && (sum_r == '0);
  assign negative  = done && s_msb;
`else
  logic unused_signed_bit;
  assign unused_signed_bit = mode_r[MODE_SIGNED_BIT];
  assign overflow = 1'b0;
  assign zero     = 1'b0;
  assign negative = 1'b0;
`endif

endmodule

// File: tb/tb_multiprecision_add_sub.sv
// Self-checking bench for multiprecision_add_sub (32-bit word, 8-bit chunks).
module tb_multiprecision_add_sub;

  localparam int unsigned W  = 32;
  localparam int unsigned NC = 4;
`ifdef ADD_SUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   mode;
  logic [W-1:0] data_in_a, data_in_b, sum;
  logic         carry_in, in_valid, in_ready, carry_out;
  logic         overflow, zero, negative, out_valid, out_ready;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  multiprecision_add_sub #(.WORD_WIDTH(32), .CHUNK_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .data_in_a (data_in_a),
    .data_in_b (data_in_b),
    .carry_in  (carry_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] s;
    logic         co, ov, z, n;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the whole word.
  task automatic model(input logic [1:0] m, input logic [W-1:0] a, b, input logic cin,
                       output logic [W-1:0] s, output logic co, ov, z, n);
    longint unsigned ua, ub, full;
    longint sa, sb, sr;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    if (!m[1]) begin
      full = ua + ub + cin;
      co   = full[32];
      sr   = sa + sb + cin;
    end else begin
      full = ua - ub - cin;
      co   = (ua < ub + cin);
      sr   = sa - sb - cin;
    end
    s  = full[31:0];
    ov = FLAGS & m[0] & ((sr > MAXS) || (sr < MINS));
    z  = FLAGS & (s == 0);
    n  = FLAGS & s[W-1];
  endtask

  task automatic scramble();
    mode      = 2'($urandom);
    data_in_a = $urandom;
    data_in_b = $urandom;
    carry_in  = 1'($urandom);
  endtask

  task automatic start_op(input logic [1:0] m, input logic [W-1:0] a, b, input logic c);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("ready_before_issue", in_ready, 1);
    mode = m; data_in_a = a; data_in_b = b; carry_in = c; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_clear", out_valid, 0);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] s, input logic co, ov, z, n);
    check({tag, "_sum"}, sum, s);
    check({tag, "_carry"}, carry_out, co);
    check({tag, "_ovf"}, overflow, ov);
    check({tag, "_zero"}, zero, z);
    check({tag, "_neg"}, negative, n);
  endtask

  task automatic run_model_op(input string tag, input logic [1:0] m, input logic [W-1:0] a, b, input logic c);
    logic [W-1:0] s;
    logic co, ov, z, n;
    int lat;
    model(m, a, b, c, s, co, ov, z, n);
    start_op(m, a, b, c);
    wait_done(lat);
    check({tag, "_latency"}, lat, NC + 1);
    check_result(tag, s, co, ov, z, n);
    release_op();
  endtask

  initial begin
    logic [W-1:0] es;
    logic eco, eov, ez, en;
    int lat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mode = '0; data_in_a = '0; data_in_b = '0; carry_in = 1'b0;

    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, FLAGS, 1'b0};
    vecs[1] = '{2'b01, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, FLAGS, 1'b0, FLAGS};
    vecs[2] = '{2'b10, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, FLAGS};
    vecs[3] = '{2'b10, 32'h0000_0005, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0, 1'b0, FLAGS, 1'b0};
    vecs[4] = '{2'b11, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, FLAGS, 1'b0, 1'b0};
    vecs[5] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, FLAGS, 1'b0};
    vecs[6] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, FLAGS, 1'b0};
    vecs[7] = '{2'b00, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0};

    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check_result("rst", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(lat);
      check($sformatf("vec%0d_latency", i), lat, NC + 1);
      check_result($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, vecs[i].ov, vecs[i].z, vecs[i].n);
      release_op();
    end

    for (int i = 0; i < 30; i++) begin
      logic [1:0] m;
      logic [W-1:0] a, b;
      m = 2'($urandom); a = $urandom; b = $urandom;
      if (i % 5 == 0) b = a;
      run_model_op($sformatf("rand%0d", i), m, a, b, 1'($urandom));
    end

    // Back-pressure: result must hold while inputs churn and out_ready is low.
    model(2'b01, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, es, eco, eov, ez, en);
    start_op(2'b01, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(lat);
    check("bp_latency", lat, NC + 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      scramble();
      in_valid = 1'($urandom);
      #1;
      check_result($sformatf("bp%0d", k), es, eco, eov, ez, en);
      check($sformatf("bp%0d_in_ready", k), in_ready, 0);
      check($sformatf("bp%0d_out_valid", k), out_valid, 1);
    end
    in_valid = 1'b0;
    release_op();

    // Reset during the second BUSY cycle aborts the operation.
    start_op(2'b00, 32'h0000_1234, 32'h0000_5678, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check_result("midrst", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_release_in_ready", in_ready, 1);
    start_op(2'b00, 32'h1, 32'h1, 1'b0);
    wait_done(lat);
    check("after_rst_latency", lat, NC + 1);
    check("after_rst_sum", sum, 32'h2);
    release_op();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
